// File: rtl/ld_st_queue_pkg.sv
// Shared types and defaults for the in-order load/store queue.
package ld_st_queue_pkg;

    localparam int LSQ_DEPTH = 8;
    localparam int LSQ_TAG_W = 8;

    // One queue slot. addr/data are only meaningful once their *_valid bit is set;
    // until then *_rob names the producer whose broadcast will resolve them.
    typedef struct packed {
        logic                 valid;
        logic                 ld_st;       // 1 = store, 0 = load
        logic [3:0]           funct3;
        logic [LSQ_TAG_W-1:0] dest_rob;
        logic                 addr_valid;
        logic [31:0]          addr;
        logic [LSQ_TAG_W-1:0] addr_rob;
        logic                 data_valid;
        logic [31:0]          data;
        logic [LSQ_TAG_W-1:0] data_rob;
    } lsq_entry_t;

    // Resolve whichever fields of a live entry are waiting on the broadcast tag.
    function automatic lsq_entry_t lsq_snoop(input lsq_entry_t e,
                                             input logic cdb_valid,
                                             input logic [LSQ_TAG_W-1:0] cdb_rob,
                                             input logic [31:0] cdb_value);
        lsq_entry_t r;
        r = e;
        if (e.valid && cdb_valid) begin
            if (!e.addr_valid && (e.addr_rob == cdb_rob)) begin
                r.addr       = cdb_value;
                r.addr_valid = 1'b1;
            end
            if (!e.data_valid && (e.data_rob == cdb_rob)) begin
                r.data       = cdb_value;
                r.data_valid = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ld_st_queue_entry.sv
// One queue slot: written on enqueue, zeroed on dequeue/flush, snoops the broadcast bus.
module ld_st_queue_entry
    import ld_st_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wr_en,
    input  lsq_entry_t           wr_entry,
    input  logic                 clr,
    input  logic                 cdb_valid,
    input  logic [LSQ_TAG_W-1:0] cdb_rob,
    input  logic [31:0]          cdb_value,
    output lsq_entry_t           entry_q
);

    lsq_entry_t entry_d;

    // Next slot value. wr_en and clr never coincide: a slot is either the tail of a
    // non-full queue or the head of a non-empty one, not both in the same cycle.
    // Snooping the write data gives the same-cycle enqueue bypass for free.
    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            entry_d = '0;
        end else if (clr) begin
            entry_d = '0;
        end else if (wr_en) begin
            entry_d = lsq_snoop(wr_entry, cdb_valid, cdb_rob, cdb_value);
        end else begin
            entry_d = lsq_snoop(entry_q, cdb_valid, cdb_rob, cdb_value);
        end
    end

    // Slot register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry_d;
    end

endmodule

// File: rtl/ld_st_queue.sv
// In-order load/store queue: circular buffer of snooping entries; head feeds mem_controller.
// Handshake: an enqueue is taken on any edge with enq_valid=1 and full=0 (full is
// from the registered count, so a same-cycle commit never frees a slot); a commit is
// taken on any edge with commit=1 and cir_q_empty=0; flush overrides both.
module ld_st_queue
    import ld_st_queue_pkg::*;
#(
    parameter int DEPTH = LSQ_DEPTH,
    parameter int TAG_W = LSQ_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq_valid,
    input  logic             enq_ld_st,
    input  logic [3:0]       enq_funct3,
    input  logic [TAG_W-1:0] enq_dest_rob,
    input  logic             enq_addr_valid,
    input  logic [31:0]      enq_addr,
    input  logic [TAG_W-1:0] enq_addr_rob,
    input  logic             enq_data_valid,
    input  logic [31:0]      enq_data,
    input  logic [TAG_W-1:0] enq_data_rob,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_rob,
    input  logic [31:0]      cdb_value,
    input  logic             commit,
    output logic             cir_q_empty,
    output logic             ld_st_data_at_commit,
    output logic [31:0]      mem_address_data_at_commit,
    output logic [TAG_W-1:0] src_rob_mem_address_data_at_commit,
    output logic             valid_mem_address_data_at_commit,
    output logic [31:0]      write_data_at_commit,
    output logic [TAG_W-1:0] src_rob_data_at_commit,
    output logic             src_valid_data_at_commit,
    output logic [TAG_W-1:0] dest_rob_data_at_commit,
    output logic [3:0]       funct3_data_at_commit
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_enq, do_deq;
    lsq_entry_t       wr_entry;
    lsq_entry_t       head_e;
    lsq_entry_t       entries [DEPTH];

    assign full        = (count_q == (PTR_W+1)'(DEPTH));
    assign cir_q_empty = (count_q == '0);
    assign do_enq      = enq_valid && !full;
    assign do_deq      = commit && !cir_q_empty;

    // Incoming entry; loads carry no store data so they are born data-resolved.
    always_comb begin
        wr_entry            = '0;
        wr_entry.valid      = 1'b1;
        wr_entry.ld_st      = enq_ld_st;
        wr_entry.funct3     = enq_funct3;
        wr_entry.dest_rob   = enq_dest_rob;
        wr_entry.addr_valid = enq_addr_valid;
        wr_entry.addr       = enq_addr;
        wr_entry.addr_rob   = enq_addr_rob;
        wr_entry.data_valid = enq_ld_st ? enq_data_valid : 1'b1;
        wr_entry.data       = enq_data;
        wr_entry.data_rob   = enq_data_rob;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        ld_st_queue_entry u_entry (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .wr_en     (do_enq && (tail_q == PTR_W'(i))),
            .wr_entry  (wr_entry),
            .clr       (do_deq && (head_q == PTR_W'(i))),
            .cdb_valid (cdb_valid),
            .cdb_rob   (cdb_rob),
            .cdb_value (cdb_value),
            .entry_q   (entries[i])
        );
    end

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_enq) tail_d = tail_q + 1'b1;
            if (do_deq) head_d = head_q + 1'b1;
            if (do_enq && !do_deq)      count_d = count_q + 1'b1;
            else if (!do_enq && do_deq) count_d = count_q - 1'b1;
        end
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Head view; forced to zero when empty so stale slot contents never leak out.
    always_comb begin
        head_e = cir_q_empty ? '0 : entries[head_q];
    end

    assign ld_st_data_at_commit               = head_e.ld_st;
    assign mem_address_data_at_commit         = head_e.addr;
    assign src_rob_mem_address_data_at_commit = head_e.addr_rob;
    assign valid_mem_address_data_at_commit   = head_e.addr_valid;
    assign write_data_at_commit               = head_e.data;
    assign src_rob_data_at_commit             = head_e.data_rob;
    assign src_valid_data_at_commit           = head_e.data_valid;
    assign dest_rob_data_at_commit            = head_e.dest_rob;
    assign funct3_data_at_commit              = head_e.funct3;

endmodule

// File: tb/tb_ld_st_queue.sv
// Directed testbench for ld_st_queue.
module tb_ld_st_queue;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        enq_valid, enq_ld_st, enq_addr_valid, enq_data_valid;
    logic [3:0]  enq_funct3;
    logic [7:0]  enq_dest_rob, enq_addr_rob, enq_data_rob;
    logic [31:0] enq_addr, enq_data;
    logic        full;
    logic        cdb_valid;
    logic [7:0]  cdb_rob;
    logic [31:0] cdb_value;
    logic        commit;
    logic        cir_q_empty, ld_st_o, addr_valid_o, data_valid_o;
    logic [31:0] addr_o, data_o;
    logic [7:0]  addr_rob_o, data_rob_o, dest_o;
    logic [3:0]  funct3_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    ld_st_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ld_st(enq_ld_st), .enq_funct3(enq_funct3),
        .enq_dest_rob(enq_dest_rob), .enq_addr_valid(enq_addr_valid), .enq_addr(enq_addr),
        .enq_addr_rob(enq_addr_rob), .enq_data_valid(enq_data_valid), .enq_data(enq_data),
        .enq_data_rob(enq_data_rob), .full(full),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
        .commit(commit), .cir_q_empty(cir_q_empty),
        .ld_st_data_at_commit(ld_st_o),
        .mem_address_data_at_commit(addr_o),
        .src_rob_mem_address_data_at_commit(addr_rob_o),
        .valid_mem_address_data_at_commit(addr_valid_o),
        .write_data_at_commit(data_o),
        .src_rob_data_at_commit(data_rob_o),
        .src_valid_data_at_commit(data_valid_o),
        .dest_rob_data_at_commit(dest_o),
        .funct3_data_at_commit(funct3_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; enq_valid = 0; enq_ld_st = 0; enq_funct3 = 0; enq_dest_rob = 0;
        enq_addr_valid = 0; enq_addr = 0; enq_addr_rob = 0; enq_data_valid = 0;
        enq_data = 0; enq_data_rob = 0; cdb_valid = 0; cdb_rob = 0; cdb_value = 0;
        commit = 0;
    endtask

    // Present an enqueue for the next edge; caller decides when to step.
    task automatic set_enq(input logic st, input logic [3:0] f3, input logic [7:0] dest,
                           input logic av, input logic [31:0] a, input logic [7:0] arob,
                           input logic dv, input logic [31:0] d, input logic [7:0] drob);
        enq_valid = 1; enq_ld_st = st; enq_funct3 = f3; enq_dest_rob = dest;
        enq_addr_valid = av; enq_addr = a; enq_addr_rob = arob;
        enq_data_valid = dv; enq_data = d; enq_data_rob = drob;
    endtask

    task automatic enq_one(input logic st, input logic [7:0] dest, input logic [31:0] a);
        set_enq(st, 4'b0010, dest, 1, a, 8'h00, 1, 32'h0, 8'h00);
        step();
        enq_valid = 0;
    endtask

    task automatic do_commit();
        commit = 1;
        step();
        commit = 0;
    endtask

    task automatic broadcast(input logic [7:0] rob, input logic [31:0] val);
        cdb_valid = 1; cdb_rob = rob; cdb_value = val;
        step();
        cdb_valid = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        step();

        // Reset state
        check("rst_empty", 32'(cir_q_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_addr", addr_o, 32'h0);
        check("rst_dest", 32'(dest_o), 32'h0);
        check("rst_flags", {28'h0, ld_st_o, addr_valid_o, data_valid_o, 1'b0}, 32'h0);
        check("rst_misc", {8'h0, addr_rob_o, data_rob_o, 4'h0, funct3_o}, 32'h0);
        check("rst_data", data_o, 32'h0);

        // Single load; data forced valid
        set_enq(0, 4'b0010, 8'h05, 1, 32'h1000, 8'h00, 0, 32'h0, 8'h00);
        step();
        enq_valid = 0;
        check("ld_empty", 32'(cir_q_empty), 32'd0);
        check("ld_addr", addr_o, 32'h1000);
        check("ld_dest", 32'(dest_o), 32'h05);
        check("ld_dvalid", 32'(data_valid_o), 32'd1);
        check("ld_avalid", 32'(addr_valid_o), 32'd1);
        check("ld_funct3", 32'(funct3_o), 32'h2);
        check("ld_kind", 32'(ld_st_o), 32'd0);
        do_commit();
        check("ld_commit_empty", 32'(cir_q_empty), 32'd1);
        check("ld_commit_addr", addr_o, 32'h0);
        do_commit();
        check("commit_when_empty", 32'(cir_q_empty), 32'd1);

        // Store resolved by two broadcasts
        set_enq(1, 4'b0001, 8'h11, 0, 32'h0, 8'h03, 0, 32'h0, 8'h07);
        step();
        enq_valid = 0;
        check("st_kind", 32'(ld_st_o), 32'd1);
        check("st_avalid0", 32'(addr_valid_o), 32'd0);
        check("st_dvalid0", 32'(data_valid_o), 32'd0);
        check("st_arob", 32'(addr_rob_o), 32'h03);
        check("st_drob", 32'(data_rob_o), 32'h07);
        broadcast(8'h07, 32'hDEADBEEF);
        check("st_dvalid1", 32'(data_valid_o), 32'd1);
        check("st_data", data_o, 32'hDEADBEEF);
        check("st_avalid_still0", 32'(addr_valid_o), 32'd0);
        broadcast(8'h03, 32'h2004);
        check("st_avalid1", 32'(addr_valid_o), 32'd1);
        check("st_addr", addr_o, 32'h2004);
        check("st_data_kept", data_o, 32'hDEADBEEF);
        broadcast(8'h03, 32'h5555);
        check("st_addr_no_reresolve", addr_o, 32'h2004);
        do_commit();
        check("st_commit_empty", 32'(cir_q_empty), 32'd1);

        // Fill to full starting mid-buffer so the drain wraps
        for (int i = 1; i <= 8; i++) begin
            check("fill_not_full", 32'(full), 32'd0);
            enq_one(0, 8'(i), 32'h100 * i);
            exp_q.push_back(32'(i));
        end
        check("full_set", 32'(full), 32'd1);
        enq_one(0, 8'h99, 32'h9999);
        check("full_9th_dropped", 32'(full), 32'd1);
        check("full_head", 32'(dest_o), 32'd1);
        set_enq(0, 4'b0010, 8'h98, 1, 32'h9898, 8'h00, 1, 32'h0, 8'h00);
        commit = 1;
        step();
        enq_valid = 0; commit = 0;
        void'(exp_q.pop_front());
        check("full_enq_commit_full", 32'(full), 32'd0);
        for (int i = 0; i < 7; i++) begin
            check("drain_empty", 32'(cir_q_empty), 32'd0);
            check("drain_dest", 32'(dest_o), exp_q.pop_front());
            do_commit();
        end
        check("drain_done_empty", 32'(cir_q_empty), 32'd1);
        check("drain_queue_used", 32'(exp_q.size()), 32'd0);

        // Enqueue bypass from same-cycle broadcast
        set_enq(0, 4'b0000, 8'h20, 0, 32'h0, 8'h0A, 0, 32'h0, 8'h00);
        cdb_valid = 1; cdb_rob = 8'h0A; cdb_value = 32'h3000;
        step();
        enq_valid = 0; cdb_valid = 0;
        check("byp_avalid", 32'(addr_valid_o), 32'd1);
        check("byp_addr", addr_o, 32'h3000);
        check("byp_funct3", 32'(funct3_o), 32'h0);
        do_commit();

        // Flush beats enqueue and commit
        enq_one(0, 8'h31, 32'h31);
        enq_one(0, 8'h32, 32'h32);
        enq_one(0, 8'h33, 32'h33);
        check("pre_flush_dest", 32'(dest_o), 32'h31);
        set_enq(0, 4'b0010, 8'h34, 1, 32'h34, 8'h00, 1, 32'h0, 8'h00);
        commit = 1; flush = 1;
        step();
        idle_inputs();
        check("flush_empty", 32'(cir_q_empty), 32'd1);
        check("flush_full", 32'(full), 32'd0);
        check("flush_dest", 32'(dest_o), 32'h0);
        step();
        check("flush_stays_empty", 32'(cir_q_empty), 32'd1);
        enq_one(0, 8'h40, 32'h40);
        check("post_flush_dest", 32'(dest_o), 32'h40);

        // Reset mid-operation
        enq_one(0, 8'h41, 32'h41);
        rst = 1;
        step();
        rst = 0;
        check("rst_mid_empty", 32'(cir_q_empty), 32'd1);
        check("rst_mid_dest", 32'(dest_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
